multicycle_ctrl: RTL

- Main control FSM for the multicycle MIPS datapath (PC, IR, MDR, A, B, ALUOut, register bank, Ula32, single unified memory).
- Sequences fetch/decode/execute and drives every mux select and register load, including the A/B/MDR/ALUOut loads left floating today.
- Adds programmable memory wait states and overflow / illegal-opcode exception entry.

---
 rtl/multicycle_ctrl_pkg.sv | 72 +++++++
 rtl/multicycle_ctrl_if.sv | 54 +++++
 rtl/multicycle_ctrl_mem_wait_counter.sv | 35 +++
 rtl/multicycle_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ctrl_pkg
//  Purpose  : Shared types and encodings for the multicycle MIPS control FSM:
//             state enumeration, opcode/funct codes, Ula32 selector codes and
//             the PCSource / ALUSrcB mux select codes.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package ctrl_pkg;

  typedef enum logic [4:0] {
    S_RESET     = 5'd0,
    S_FETCH     = 5'd1,
    S_DECODE    = 5'd2,
    S_R_EXEC    = 5'd3,
    S_R_WB      = 5'd4,
    S_ADDI_EXEC = 5'd5,
    S_ADDI_WB   = 5'd6,
    S_MEM_ADDR  = 5'd7,
    S_MEM_READ  = 5'd8,
    S_MEM_WB    = 5'd9,
    S_MEM_WRITE = 5'd10,
    S_BRANCH    = 5'd11,
    S_JUMP      = 5'd12,
    S_EXC       = 5'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_XOR = 6'h26;

  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_SUB = 3'b010;
  localparam logic [2:0] ALU_AND = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b110;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_EXC    = 2'b11;

  localparam logic [1:0] ALUSRCB_B      = 2'b00;
  localparam logic [1:0] ALUSRCB_FOUR   = 2'b01;
  localparam logic [1:0] ALUSRCB_IMM    = 2'b10;
  localparam logic [1:0] ALUSRCB_IMM_SH = 2'b11;

  // Returns {valid, alu_op} for an R-type funct field. Invalid funct codes
  // return valid=0 and an all-zero selector.
  function automatic logic [3:0] decode_funct(input logic [5:0] funct);
    logic [3:0] res;
    res = 4'b0000;
    case (funct)
      FN_ADD:  res = {1'b1, ALU_ADD};
      FN_SUB:  res = {1'b1, ALU_SUB};
      FN_AND:  res = {1'b1, ALU_AND};
      FN_XOR:  res = {1'b1, ALU_XOR};
      default: res = 4'b0000;
    endcase
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/multicycle_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : multicycle_ctrl_if
//  Purpose  : Control bundle between the multicycle controller and datapath.
//             master = controller side (drives selects/loads, reads flags),
//             slave  = datapath side.
//  Signals  : Op, Funct, Zero, Overflow (datapath -> controller);
//             PCWrite..EPCWrite mux selects and load strobes, Cause, State
//             (controller -> datapath)
//  Revision : 1.0 - initial release
// ============================================================================
interface multicycle_ctrl_if;

  logic [5:0] Op;
  logic [5:0] Funct;
  logic       Zero;
  logic       Overflow;

  logic       PCWrite;
  logic       PCWriteCond;
  logic       IorD;
  logic       MemWrite;
  logic       MemtoReg;
  logic       IRWrite;
  logic       MDRLoad;
  logic       ALoad;
  logic       BLoad;
  logic       ALUOutLoad;
  logic [1:0] PCSource;
  logic [2:0] ALUOp;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic       RegWrite;
  logic       RegDst;
  logic       EPCWrite;
  logic       Cause;
  logic [4:0] State;

  modport master (
    input  Op, Funct, Zero, Overflow,
    output PCWrite, PCWriteCond, IorD, MemWrite, MemtoReg, IRWrite, MDRLoad,
           ALoad, BLoad, ALUOutLoad, PCSource, ALUOp, ALUSrcA, ALUSrcB,
           RegWrite, RegDst, EPCWrite, Cause, State
  );

  modport slave (
    output Op, Funct, Zero, Overflow,
    input  PCWrite, PCWriteCond, IorD, MemWrite, MemtoReg, IRWrite, MDRLoad,
           ALoad, BLoad, ALUOutLoad, PCSource, ALUOp, ALUSrcA, ALUSrcB,
           RegWrite, RegDst, EPCWrite, Cause, State
  );

endinterface
`default_nettype wire

// File: rtl/multicycle_ctrl_mem_wait_counter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_wait_counter
//  Purpose  : 3-bit memory wait-state counter shared by FETCH and MEM_READ.
//             Counts up while enabled, saturating at MEM_WAIT; done is high
//             once the count has reached MEM_WAIT (immediately if 0).
//  Ports    : Clk, Reset (sync, active-low), clear, enable, done
//  Revision : 1.0 - initial release
// ============================================================================
module mem_wait_counter #(
  parameter int MEM_WAIT = 1
) (
  input  wire logic Clk,
  input  wire logic Reset,
  input  wire logic clear,
  input  wire logic enable,
  output logic      done
);

  localparam logic [2:0] c_wait_max = 3'(MEM_WAIT);

  logic [2:0] r_count;

  always_ff @(posedge Clk) begin
    if (!Reset || clear) begin
      r_count <= 3'd0;
    end else if (enable && (r_count != c_wait_max)) begin
      r_count <= r_count + 3'd1;
    end
  end

  assign done = (r_count == c_wait_max);

endmodule
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : multicycle_ctrl
//  Purpose  : Main control FSM for the multicycle MIPS datapath. Sequences
//             fetch/decode/execute, drives every mux select and register
//             load, inserts MEM_WAIT wait states on memory reads and enters
//             an exception state on overflow or illegal opcode/funct.
//  Ports    : Clk   - system clock (rising edge)
//             Reset - synchronous, active-low
//             bus   - multicycle_ctrl_if.master (flags in, controls out)
//  Revision : 1.0 - initial release
// ============================================================================
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int         MEM_WAIT       = 1,
  parameter logic [1:0] EXC_VECTOR_SEL = 2'b11
) (
  input  wire logic           Clk,
  input  wire logic           Reset,
  multicycle_ctrl_if.master   bus
);

  state_t     r_state;
  state_t     w_next_state;
  logic       r_cause;
  logic       w_cause_load;
  logic       w_cause_val;
  logic       w_wait_done;
  logic       w_wait_clear;
  logic       w_wait_en;
  logic [3:0] w_fn_dec;
  logic       w_fn_arith;
  logic       w_unused_zero;

  // Zero is gated with PCWriteCond outside the controller.
  assign w_unused_zero = bus.Zero;

  assign w_fn_dec   = decode_funct(bus.Funct);
  assign w_fn_arith = (bus.Funct == FN_ADD) || (bus.Funct == FN_SUB);

  // Counter restarts on every state change so each FETCH / MEM_READ visit
  // begins at zero.
  assign w_wait_clear = (w_next_state != r_state);
  assign w_wait_en    = (r_state == S_FETCH) || (r_state == S_MEM_READ);

  mem_wait_counter #(
    .MEM_WAIT (MEM_WAIT)
  ) u_wait (
    .Clk    (Clk),
    .Reset  (Reset),
    .clear  (w_wait_clear),
    .enable (w_wait_en),
    .done   (w_wait_done)
  );

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_state <= S_RESET;
      r_cause <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_cause_load) begin
        r_cause <= w_cause_val;
      end
    end
  end

  assign bus.State = r_state;
  assign bus.Cause = r_cause;

  always_comb begin
    w_next_state    = r_state;
    w_cause_load    = 1'b0;
    w_cause_val     = 1'b0;
    bus.PCWrite     = 1'b0;
    bus.PCWriteCond = 1'b0;
    bus.IorD        = 1'b0;
    bus.MemWrite    = 1'b0;
    bus.MemtoReg    = 1'b0;
    bus.IRWrite     = 1'b0;
    bus.MDRLoad     = 1'b0;
    bus.ALoad       = 1'b0;
    bus.BLoad       = 1'b0;
    bus.ALUOutLoad  = 1'b0;
    bus.PCSource    = PCSRC_ALU;
    bus.ALUOp       = 3'b000;
    bus.ALUSrcA     = 1'b0;
    bus.ALUSrcB     = ALUSRCB_B;
    bus.RegWrite    = 1'b0;
    bus.RegDst      = 1'b0;
    bus.EPCWrite    = 1'b0;

    case (r_state)
      S_RESET: begin
        w_next_state = S_FETCH;
      end

      S_FETCH: begin
        bus.ALUSrcB = ALUSRCB_FOUR;
        bus.ALUOp   = ALU_ADD;
        if (w_wait_done) begin
          bus.IRWrite  = 1'b1;
          bus.PCWrite  = 1'b1;
          w_next_state = S_DECODE;
        end
      end

      S_DECODE: begin
        // Speculative branch target into ALUOut while A/B load.
        bus.ALoad      = 1'b1;
        bus.BLoad      = 1'b1;
        bus.ALUSrcB    = ALUSRCB_IMM_SH;
        bus.ALUOp      = ALU_ADD;
        bus.ALUOutLoad = 1'b1;
        case (bus.Op)
          OP_RTYPE:     w_next_state = S_R_EXEC;
          OP_LW, OP_SW: w_next_state = S_MEM_ADDR;
          OP_BEQ:       w_next_state = S_BRANCH;
          OP_J:         w_next_state = S_JUMP;
          OP_ADDI:      w_next_state = S_ADDI_EXEC;
          default: begin
            w_next_state = S_EXC;
            w_cause_load = 1'b1;
            w_cause_val  = 1'b0;
          end
        endcase
      end

      S_R_EXEC: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = ALUSRCB_B;
        if (!w_fn_dec[3]) begin
          w_next_state = S_EXC;
          w_cause_load = 1'b1;
          w_cause_val  = 1'b0;
        end else begin
          bus.ALUOp      = w_fn_dec[2:0];
          bus.ALUOutLoad = 1'b1;
          if (bus.Overflow && w_fn_arith) begin
            w_next_state = S_EXC;
            w_cause_load = 1'b1;
            w_cause_val  = 1'b1;
          end else begin
            w_next_state = S_R_WB;
          end
        end
      end

      S_R_WB: begin
        bus.RegWrite = 1'b1;
        bus.RegDst   = 1'b1;
        w_next_state = S_FETCH;
      end

      S_ADDI_EXEC: begin
        bus.ALUSrcA    = 1'b1;
        bus.ALUSrcB    = ALUSRCB_IMM;
        bus.ALUOp      = ALU_ADD;
        bus.ALUOutLoad = 1'b1;
        if (bus.Overflow) begin
          w_next_state = S_EXC;
          w_cause_load = 1'b1;
          w_cause_val  = 1'b1;
        end else begin
          w_next_state = S_ADDI_WB;
        end
      end

      S_ADDI_WB: begin
        bus.RegWrite = 1'b1;
        w_next_state = S_FETCH;
      end

      S_MEM_ADDR: begin
        // Address arithmetic never traps on overflow.
        bus.ALUSrcA    = 1'b1;
        bus.ALUSrcB    = ALUSRCB_IMM;
        bus.ALUOp      = ALU_ADD;
        bus.ALUOutLoad = 1'b1;
        w_next_state   = (bus.Op == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      end

      S_MEM_READ: begin
        bus.IorD = 1'b1;
        if (w_wait_done) begin
          bus.MDRLoad  = 1'b1;
          w_next_state = S_MEM_WB;
        end
      end

      S_MEM_WB: begin
        bus.RegWrite = 1'b1;
        bus.MemtoReg = 1'b1;
        w_next_state = S_FETCH;
      end

      S_MEM_WRITE: begin
        bus.IorD     = 1'b1;
        bus.MemWrite = 1'b1;
        w_next_state = S_FETCH;
      end

      S_BRANCH: begin
        bus.ALUSrcA     = 1'b1;
        bus.ALUSrcB     = ALUSRCB_B;
        bus.ALUOp       = ALU_SUB;
        bus.PCWriteCond = 1'b1;
        bus.PCSource    = PCSRC_ALUOUT;
        w_next_state    = S_FETCH;
      end

      S_JUMP: begin
        bus.PCWrite  = 1'b1;
        bus.PCSource = PCSRC_JUMP;
        w_next_state = S_FETCH;
      end

      S_EXC: begin
        bus.EPCWrite = 1'b1;
        bus.PCWrite  = 1'b1;
        bus.PCSource = EXC_VECTOR_SEL;
        w_next_state = S_FETCH;
      end

      default: begin
        w_next_state = S_RESET;
      end
    endcase
  end

endmodule
`default_nettype wire
